// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame debounce, key events and 8-deep nibble history.
// Ports: clk, rst_n (async, active-low); row[3:0] active-low row drive; col[3:0] active-low column sense;
// key_code[3:0] {row,col} of last accepted key; key_valid one-clk event strobe; key_down debounced hold;
// key_hist[31:0] last 8 codes, newest in [3:0]. Define KEYPAD_REPEAT_EN to add auto-repeat while held.
module keypad_scan #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [31:0] key_hist
);
  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int CW = $clog2(TICK_DIV);
  if (TICK_DIV < 4 || DEBOUNCE_FRAMES < 2 || DEBOUNCE_FRAMES > 15 || REPEAT_FRAMES < 1) begin : g_bad_cfg
    $error("keypad_scan: illegal parameter combination");
  end
  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;
  state_t      state_q;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [3:0]  row_q, s1_q, s2_q;
  logic [15:0] acc_q, frame_q;
  logic        frame_done_q, tick, none, single;
  logic [3:0]  idx, cand_q, cnt_q, cnt_inc, key_code_q;
  logic        key_valid_q, key_down_q;
  logic [31:0] key_hist_q;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep_q, rep_inc;
  assign rep_inc = rep_q + 1'b1;
`endif
  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign key_hist  = key_hist_q;
  assign tick      = tcnt_q == CW'(TICK_DIV - 1);
  assign tcnt_d    = tick ? '0 : tcnt_q + 1'b1;
  assign row_idx_d = row_idx_q + 2'd1;
  assign cnt_inc   = cnt_q + 4'd1;
  always_comb begin
    none   = frame_q == '0;
    single = $onehot(frame_q);
    idx    = '0;
    for (int i = 0; i < 16; i++) if (frame_q[i]) idx = 4'(i);
  end
  // Columns are sampled just before the row moves on, so the driven row has settled for TICK_DIV-1 clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q       <= '0;
      row_idx_q    <= '0;
      row_q        <= 4'b1110;
      s1_q         <= 4'hF;
      s2_q         <= 4'hF;
      acc_q        <= '0;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      tcnt_q       <= tcnt_d;
      s1_q         <= col;
      s2_q         <= s1_q;
      frame_done_q <= tick && row_idx_q == 2'd3;
      if (tick) begin
        row_idx_q <= row_idx_d;
        row_q     <= ~(4'b1 << row_idx_d);
        acc_q[{row_idx_q, 2'b00} +: 4] <= ~s2_q;
        if (row_idx_q == 2'd3) frame_q <= {~s2_q, acc_q[11:0]};
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      key_hist_q  <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      if (frame_done_q) begin
        case (state_q)
          IDLE: if (single) begin
            state_q <= DB_PRESS;
            cand_q  <= idx;
            cnt_q   <= 4'd1;
          end
          DB_PRESS: if (single && idx == cand_q) begin
            if (cnt_inc == 4'(DEBOUNCE_FRAMES)) begin
              state_q     <= PRESSED;
              cnt_q       <= '0;
              key_code_q  <= cand_q;
              key_down_q  <= 1'b1;
              key_valid_q <= 1'b1;
              key_hist_q  <= {key_hist_q[27:0], cand_q};
`ifdef KEYPAD_REPEAT_EN
              rep_q       <= '0;
`endif
            end else cnt_q <= cnt_inc;
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
          PRESSED: begin
            if (none) begin
              state_q <= DB_RELEASE;
              cnt_q   <= 4'd1;
`ifdef KEYPAD_REPEAT_EN
              rep_q   <= '0;
`endif
            end
`ifdef KEYPAD_REPEAT_EN
            else if (single && idx == key_code_q) begin
              if (rep_inc == RW'(REPEAT_FRAMES)) begin
                rep_q       <= '0;
                key_valid_q <= 1'b1;
                key_hist_q  <= {key_hist_q[27:0], key_code_q};
              end else rep_q <= rep_inc;
            end else rep_q <= '0;
`endif
          end
          DB_RELEASE: if (none) begin
            if (cnt_inc == 4'(DEBOUNCE_FRAMES)) begin
              state_q    <= IDLE;
              cnt_q      <= '0;
              key_down_q <= 1'b0;
            end else cnt_q <= cnt_inc;
          end else begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scan-multiplexed 4x4 matrix keypad reader; the input-side counterpart of the segment display scanner.
- Drives one keypad row low at a time and samples the four column lines.
- Debounces over whole scan frames and emits a 4-bit key code with a one-cycle valid strobe.
- Keeps a 32-bit history of the last 8 keys, nibble-packed in the same layout the display scanner consumes, so the history can feed the display directly.

Parameters:
- CLK_HZ, 50_000_000, clk frequency in Hz.
- SCAN_HZ, 1000, row-step rate; TICK_DIV = CLK_HZ/SCAN_HZ clocks per row; TICK_DIV >= 4 required.
- DEBOUNCE_FRAMES, 4, consecutive identical frames needed to accept a press or a release; legal range 2..15.
- REPEAT_FRAMES, 100, frames per auto-repeat; used only with KEYPAD_REPEAT_EN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- row  output  4  row drive, active-low one-hot; bit i low drives row i.
- col  input  4  column sense, active-low, externally pulled up; asynchronous to clk.
- key_code  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  output  1  one-clk pulse per accepted key event.
- key_down  output  1  high while a debounced key is held.
- key_hist  output  32  last 8 codes; newest in [3:0], oldest in [31:28].

Behaviour:
- Reset (asynchronous) values: row=4'b1110, row_idx=0, tick counter=0, both col sync flops=4'hF, frame accumulator cleared, state=IDLE, debounce/repeat counters=0, key_code=0, key_valid=0, key_down=0, key_hist=0.
- Reset mid-operation aborts any debounce in progress. No event is emitted on reset release.
- Timebase:
  - Tick counter counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (count == TICK_DIV-1).
- Row advance: on tick, row_idx increments 0..3 and wraps to 0; row = ~(4'b1 << row_idx).
- col sampling:
  - col passes through a 2-flop synchroniser.
  - On tick, before the row advances, the synchronised col is sampled as pressed = ~col into frame[row_idx*4 +: 4]. The row has then been stable for TICK_DIV-1 cycles.
- Frame completion:
  - The tick with row_idx==3 registers the completed 16-bit frame and pulses frame_done on the next cycle.
  - Frame class: NONE (0 bits set), SINGLE(k) (exactly 1 bit set, k = bit index), MULTI (>=2 bits set, ghosting).
- FSM, evaluated only on frame_done:
  - IDLE: SINGLE(k) -> DB_PRESS, cand=k, cnt=1. NONE or MULTI -> stay in IDLE.
  - DB_PRESS, frame SINGLE(cand): cnt++. When the new cnt equals DEBOUNCE_FRAMES -> PRESSED.
  - DB_PRESS, any other frame: -> IDLE, cnt=0.
  - On entering PRESSED: key_code<=cand, key_down<=1, key_valid=1 for exactly one clk, key_hist <= {key_hist[27:0], cand}.
  - PRESSED: NONE -> DB_RELEASE, cnt=1. SINGLE of any key or MULTI -> stay in PRESSED, no event; a second key while one is held is ignored.
  - DB_RELEASE: NONE -> cnt++; when it reaches DEBOUNCE_FRAMES -> IDLE, key_down<=0, key_code held. Any non-NONE frame -> PRESSED, no new event.
- Latency: key_valid rises 2 clk after the row-3 tick of the qualifying frame, not counting the 2-cycle col synchroniser.
- key_code holds its value between events.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined: in PRESSED, a repeat counter counts frames of SINGLE(key_code).
  - When it reaches REPEAT_FRAMES: emit key_valid plus a history shift with the same code, then reset the counter to 0.
  - Any other frame clears the repeat counter.
- Undefined: exactly one event per debounced press; no repeat counter logic exists.

Test Plan (CLK_HZ=400, SCAN_HZ=100 -> TICK_DIV=4, 16 clk/frame, DEBOUNCE_FRAMES=3):
- Reset, no key -> row cycles 1110,1101,1011,0111 every 4 clk; key_valid never asserts; key_hist=0.
- Hold row2/col1 (col=4'b1101 only while row=1011) for 5 frames -> single key_valid pulse, key_code=4'h9, key_down=1, key_hist=32'h00000009.
- Press key 9 for 2 frames, release, press again briefly -> no key_valid emitted (debounce never reaches 3).
- Press 9, release 3 frames, press 4'h3 -> two pulses; key_hist=32'h00000093; key_down falls after the 3rd NONE frame.
- Hold keys 0 and 5 together from IDLE -> MULTI; no event. Hold 0, add 5 while in PRESSED -> no second event.
- KEYPAD_REPEAT_EN with REPEAT_FRAMES=4, hold 9 for 3+12 frames -> 4 pulses total (initial + 3 repeats), key_hist=32'h00009999.
